// File: rtl/cei_obi_addr_demux.sv
// cei_obi_addr_demux: one-master-to-N-slave OBI demux with rule-table decode, in-order response routing and error responder.
// Define CEI_OBI_DEMUX_RULE_WR_EN to expose the rule_* write ports and make the rule table writable.
package cei_obi_addr_demux_pkg;
  typedef struct packed {
    logic        valid;
    logic [7:0]  idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;
  // System crossbar map; entry 5 overlaps entry 3 on purpose, entry 3 wins there.
  localparam addr_map_rule_t [5:0] SYS_XBAR_RULES = '{
    '{1'b1, 8'd5, 32'hF000_0000, 32'hF011_0000},
    '{1'b1, 8'd4, 32'h2000_0000, 32'h3000_0000},
    '{1'b1, 8'd3, 32'hF010_0000, 32'hF020_0000},
    '{1'b1, 8'd2, 32'h0002_0000, 32'h0003_0000},
    '{1'b1, 8'd1, 32'h0001_0000, 32'h0002_0000},
    '{1'b1, 8'd0, 32'h0000_0000, 32'h0001_0000}
  };
endpackage

module cei_obi_addr_demux
  import cei_obi_addr_demux_pkg::*;
#(
  parameter int NUM_SLAVES = 6,
  parameter int NUM_RULES = 6,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter addr_map_rule_t [NUM_RULES-1:0] RST_RULES = SYS_XBAR_RULES,
  localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1,
  localparam int RW = NUM_RULES > 1 ? $clog2(NUM_RULES) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_i,
  output logic                                  gnt_o,
  input  logic [ADDR_WIDTH-1:0]                 addr_i,
  input  logic                                  we_i,
  input  logic [DATA_WIDTH/8-1:0]               be_i,
  input  logic [DATA_WIDTH-1:0]                 wdata_i,
  output logic                                  rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic                                  err_o,
  output logic [NUM_SLAVES-1:0]                 slv_req_o,
  input  logic [NUM_SLAVES-1:0]                 slv_gnt_i,
  output logic [ADDR_WIDTH-1:0]                 slv_addr_o,
  output logic                                  slv_we_o,
  output logic [DATA_WIDTH/8-1:0]               slv_be_o,
  output logic [DATA_WIDTH-1:0]                 slv_wdata_o,
  input  logic [NUM_SLAVES-1:0]                 slv_rvalid_i,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] slv_rdata_i,
`ifdef CEI_OBI_DEMUX_RULE_WR_EN
  input  logic                                  rule_we_i,
  input  logic [RW-1:0]                         rule_sel_i,
  input  logic                                  rule_valid_i,
  input  logic [SW-1:0]                         rule_idx_i,
  input  logic [ADDR_WIDTH-1:0]                 rule_start_i,
  input  logic [ADDR_WIDTH-1:0]                 rule_end_i,
`endif
  output logic [CW-1:0]                         outstanding_o
);
  localparam int TW = $clog2(NUM_SLAVES + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [TW-1:0] ERR = TW'(NUM_SLAVES);
  localparam logic [7:0] NS8 = 8'(NUM_SLAVES);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PLAST = PW'(MAX_OUTSTANDING - 1);
  addr_map_rule_t [NUM_RULES-1:0] w_rules;
  logic [TW-1:0] w_tgt, w_head, r_last;
  logic [TW-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic r_err_v, w_busy, w_fwd, w_push, w_pop, w_head_err;

`ifdef CEI_OBI_DEMUX_RULE_WR_EN
  localparam logic [RW:0] NR = (RW+1)'(NUM_RULES);
  addr_map_rule_t [NUM_RULES-1:0] r_rules;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_rules <= RST_RULES;
    else if (rule_we_i && {1'b0, rule_sel_i} < NR)
      r_rules[rule_sel_i] <= '{rule_valid_i, 8'(rule_idx_i), 32'(rule_start_i), 32'(rule_end_i)};
  assign w_rules = r_rules;
`else
  assign w_rules = RST_RULES;
`endif

  // Scan from the top so the lowest matching index is the last to overwrite.
  always_comb begin
    w_tgt = ERR;
    for (int i = NUM_RULES - 1; i >= 0; i--)
      if (w_rules[i].valid && w_rules[i].idx < NS8 &&
          addr_i >= ADDR_WIDTH'(w_rules[i].start_addr) && addr_i < ADDR_WIDTH'(w_rules[i].end_addr))
        w_tgt = TW'(w_rules[i].idx);
  end

  assign w_busy = r_cnt != '0;
  assign w_head = r_fifo[r_rptr];
  assign w_head_err = w_head == ERR;
  // Only one target may be in flight at a time, which keeps responses ordered.
  assign w_fwd = !rst_i && r_cnt < MAXC && (!w_busy || w_tgt == r_last);
  assign gnt_o = w_fwd && req_i && (w_tgt == ERR || slv_gnt_i[w_tgt]);
  assign w_push = gnt_o;
  assign w_pop = !rst_i && w_busy && (w_head_err ? r_err_v : slv_rvalid_i[w_head]);
  assign rvalid_o = w_pop;
  assign err_o = w_pop && w_head_err;
  assign rdata_o = (!rst_i && w_busy && !w_head_err) ? slv_rdata_i[w_head] : '0;
  assign outstanding_o = r_cnt;
  assign slv_addr_o = addr_i;
  assign slv_we_o = we_i;
  assign slv_be_o = be_i;
  assign slv_wdata_o = wdata_i;

  always_comb begin
    slv_req_o = '0;
    if (w_fwd && w_tgt != ERR) slv_req_o[w_tgt] = req_i;
  end

  always_ff @(posedge clk_i)
    if (w_push) r_fifo[r_wptr] <= w_tgt;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt <= '0;
      r_last <= ERR;
      r_err_v <= 1'b0;
    end else begin
      r_wptr <= w_push ? (r_wptr == PLAST ? '0 : r_wptr + 1'b1) : r_wptr;
      r_rptr <= w_pop ? (r_rptr == PLAST ? '0 : r_rptr + 1'b1) : r_rptr;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_last <= w_push ? w_tgt : r_last;
      r_err_v <= w_push && w_tgt == ERR;
    end

`ifndef SYNTHESIS
  logic [NUM_SLAVES-1:0] w_exp_rv;
  always_comb begin
    w_exp_rv = '0;
    if (w_busy && !w_head_err) w_exp_rv[w_head] = 1'b1;
  end
  a_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) (slv_rvalid_i & ~w_exp_rv) == '0)
    else $warning("cei_obi_addr_demux: stray slave response ignored");
`endif
endmodule

// File: tb/tb_cei_obi_addr_demux.sv
// tb_cei_obi_addr_demux: directed stimulus, queue-based reference model checked every cycle, plus literal expectations.
module tb_cei_obi_addr_demux;
  localparam int ERR = 6;
  localparam int MAXO = 4;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = 32'h1234_5678;
  logic [3:0] be = 4'hF;
  logic [5:0] slv_gnt = '1, slv_rvalid = '0, slv_req;
  logic [5:0][31:0] slv_rdata = '0;
  logic gnt, rvalid, err, slv_we;
  logic [31:0] rdata, slv_addr, slv_wdata;
  logic [3:0] slv_be;
  logic [2:0] outstanding;
`ifdef CEI_OBI_DEMUX_RULE_WR_EN
  logic rule_we = 1'b0, rule_valid = 1'b0;
  logic [2:0] rule_sel = '0, rule_idx = '0;
  logic [31:0] rule_start = '0, rule_end = '0;
`endif
  int n_vec = 0, n_miss = 0;

  always #5 clk = ~clk;

  cei_obi_addr_demux dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .slv_req_o(slv_req),
    .slv_gnt_i(slv_gnt), .slv_addr_o(slv_addr), .slv_we_o(slv_we), .slv_be_o(slv_be),
    .slv_wdata_o(slv_wdata), .slv_rvalid_i(slv_rvalid), .slv_rdata_i(slv_rdata),
`ifdef CEI_OBI_DEMUX_RULE_WR_EN
    .rule_we_i(rule_we), .rule_sel_i(rule_sel), .rule_valid_i(rule_valid), .rule_idx_i(rule_idx),
    .rule_start_i(rule_start), .rule_end_i(rule_end),
`endif
    .outstanding_o(outstanding)
  );

  // Reference model: address map as plain arrays, outstanding targets as a queue.
  logic [31:0] m_st [6], m_en [6];
  int m_ix [6];
  bit m_v [6];
  int q [$];
  int last = ERR;
  bit err_pend = 1'b0;

  typedef struct packed {
    logic gnt;
    logic [5:0] sreq;
    logic rv;
    logic er;
    logic [31:0] rd;
    logic [31:0] cnt;
    logic [31:0] tgt;
  } exp_t;
  exp_t ce, ue;

  task automatic load_rst();
    m_st[0] = 32'h0000_0000; m_en[0] = 32'h0001_0000; m_ix[0] = 0;
    m_st[1] = 32'h0001_0000; m_en[1] = 32'h0002_0000; m_ix[1] = 1;
    m_st[2] = 32'h0002_0000; m_en[2] = 32'h0003_0000; m_ix[2] = 2;
    m_st[3] = 32'hF010_0000; m_en[3] = 32'hF020_0000; m_ix[3] = 3;
    m_st[4] = 32'h2000_0000; m_en[4] = 32'h3000_0000; m_ix[4] = 4;
    m_st[5] = 32'hF000_0000; m_en[5] = 32'hF011_0000; m_ix[5] = 5;
    for (int i = 0; i < 6; i++) m_v[i] = 1'b1;
  endtask

  function automatic int decode(logic [31:0] a);
    for (int i = 0; i < 6; i++)
      if (m_v[i] && a >= m_st[i] && a < m_en[i]) return m_ix[i];
    return ERR;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    int t;
    bit can;
    e = '0;
    if (rst) return e;
    t = decode(addr);
    can = q.size() < MAXO && (q.size() == 0 || t == last);
    e.gnt = req && can && (t == ERR || slv_gnt[t]);
    if (req && can && t != ERR) e.sreq[t] = 1'b1;
    if (q.size() != 0) begin
      e.rv = q[0] == ERR ? err_pend : slv_rvalid[q[0]];
      e.er = e.rv && q[0] == ERR;
      e.rd = (e.rv && q[0] != ERR) ? slv_rdata[q[0]] : 32'h0;
    end
    e.cnt = 32'(q.size());
    e.tgt = 32'(t);
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      last = ERR;
      err_pend = 1'b0;
      load_rst();
    end else begin
      ue = model_exp();
      if (ue.rv) void'(q.pop_front());
      if (ue.gnt) begin
        q.push_back(int'(ue.tgt));
        last = int'(ue.tgt);
      end
      err_pend = ue.gnt && ue.tgt == ERR;
`ifdef CEI_OBI_DEMUX_RULE_WR_EN
      if (rule_we && rule_sel < 3'd6) begin
        m_st[rule_sel] = rule_start; m_en[rule_sel] = rule_end;
        m_ix[rule_sel] = int'(rule_idx); m_v[rule_sel] = rule_valid;
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ce = model_exp();
    chk("gnt_o", gnt, ce.gnt);
    chk("slv_req_o", slv_req, ce.sreq);
    chk("rvalid_o", rvalid, ce.rv);
    chk("err_o", err, ce.er);
    chk("outstanding_o", outstanding, ce.cnt);
    if (ce.rv || rst) chk("rdata_o", rdata, ce.rd);
    chk("slv_addr_o", slv_addr, addr);
    chk("slv_we_be_wdata", {slv_we, slv_be, slv_wdata}, {we, be, wdata});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bnd_a [10];
  logic [5:0] bnd_r [10];

  initial begin
    bnd_a[0] = 32'h0000_FFFF; bnd_r[0] = 6'b000001;
    bnd_a[1] = 32'h0001_0000; bnd_r[1] = 6'b000010;
    bnd_a[2] = 32'h0002_FFFF; bnd_r[2] = 6'b000100;
    bnd_a[3] = 32'h2000_0000; bnd_r[3] = 6'b010000;
    bnd_a[4] = 32'h2FFF_FFFF; bnd_r[4] = 6'b010000;
    bnd_a[5] = 32'hF000_0000; bnd_r[5] = 6'b100000;
    bnd_a[6] = 32'hF00F_FFFF; bnd_r[6] = 6'b100000;
    bnd_a[7] = 32'hF010_0000; bnd_r[7] = 6'b001000;
    bnd_a[8] = 32'hF010_FFFF; bnd_r[8] = 6'b001000;
    bnd_a[9] = 32'hF01F_FFFF; bnd_r[9] = 6'b001000;
    // Reset holds everything quiet even with an unmapped request pending.
    req = 1'b1; addr = 32'h8000_0000;
    cyc(); cyc();
    chk("rst_gnt", gnt, 0); chk("rst_rvalid", rvalid, 0); chk("rst_outst", outstanding, 0);
    rst = 1'b0; req = 1'b0;
    cyc();
    // Basic read to slave 3.
    req = 1'b1; addr = 32'hF010_0010; #1;
    chk("rd3_req", slv_req, 6'b001000); chk("rd3_gnt", gnt, 1);
    cyc(); req = 1'b0; #1;
    chk("rd3_outst", outstanding, 1);
    slv_rvalid = 6'b001000; slv_rdata[3] = 32'hDEAD_BEEF; #1;
    chk("rd3_rvalid", rvalid, 1); chk("rd3_rdata", rdata, 32'hDEAD_BEEF); chk("rd3_err", err, 0);
    cyc(); slv_rvalid = '0; #1;
    chk("rd3_drain", outstanding, 0);
    // Decode boundaries with grants withheld.
    slv_gnt = '0; req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr = bnd_a[i]; #1;
      chk("bnd_req", slv_req, bnd_r[i]); chk("bnd_gnt", gnt, 0);
      cyc();
    end
    // Back-to-back unmapped accesses.
    slv_gnt = '1; addr = 32'h8000_0000; #1;
    chk("err_gnt", gnt, 1); chk("err_noreq", slv_req, 0);
    cyc(); addr = 32'hF020_0000; #1;
    chk("err2_gnt", gnt, 1); chk("err1_rv", rvalid, 1); chk("err1_err", err, 1); chk("err1_rd", rdata, 0);
    cyc(); req = 1'b0; #1;
    chk("err2_rv", rvalid, 1); chk("err2_err", err, 1);
    cyc();
    chk("err_idle", rvalid, 0); chk("err_outst", outstanding, 0);
    // Fill to MAX_OUTSTANDING on slave 4.
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h2000_0000 + 32'(4 * i);
      cyc();
    end
    addr = 32'h2000_0010; #1;
    chk("full_outst", outstanding, 4); chk("full_gnt", gnt, 0); chk("full_req", slv_req, 0);
    slv_rvalid = 6'b010000; slv_rdata[4] = 32'h4444_0040; #1;
    chk("full_rv", rvalid, 1); chk("full_rd", rdata, 32'h4444_0040); chk("full_popgnt", gnt, 0);
    cyc(); slv_rvalid = '0; #1;
    chk("full_outst3", outstanding, 3); chk("full_gnt2", gnt, 1);
    cyc(); req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slv_rvalid = 6'b010000; slv_rdata[4] = 32'h4444_0041 + 32'(i); #1;
      chk("drain_rd", rdata, 32'h4444_0041 + 32'(i));
      cyc();
    end
    slv_rvalid = '0; #1;
    chk("drain_outst", outstanding, 0);
    // Target switch stalls until the previous target drains.
    req = 1'b1; addr = 32'h2000_0020; #1;
    chk("sw_gnt4", gnt, 1);
    cyc(); addr = 32'hF010_0010; #1;
    chk("sw_stall_gnt", gnt, 0); chk("sw_stall_req", slv_req, 0);
    slv_rvalid = 6'b001000; slv_rdata[3] = 32'hBAD0_BAD0; #1;
    chk("sw_stray", rvalid, 0);
    cyc(); slv_rvalid = 6'b010000; slv_rdata[4] = 32'h4444_AAAA; #1;
    chk("sw_rv4", rdata, 32'h4444_AAAA); chk("sw_still", gnt, 0);
    cyc(); slv_rvalid = '0; #1;
    chk("sw_gnt3", gnt, 1); chk("sw_req3", slv_req, 6'b001000);
    cyc(); req = 1'b0; slv_rvalid = 6'b001000; slv_rdata[3] = 32'h3333_CCCC; #1;
    chk("sw_rd3", rdata, 32'h3333_CCCC);
    cyc(); slv_rvalid = '0;
`ifdef CEI_OBI_DEMUX_RULE_WR_EN
    // Remap entry 3 while slave 3 traffic is in flight.
    req = 1'b1; addr = 32'hF010_0010;
    cyc();
    rule_we = 1'b1; rule_sel = 3'd3; rule_valid = 1'b1; rule_idx = 3'd1;
    rule_start = 32'hF010_0000; rule_end = 32'hF010_8000; addr = 32'hF010_0004; #1;
    chk("rw_same_cyc", slv_req, 6'b001000);
    cyc(); rule_we = 1'b0; #1;
    chk("rw_stall", slv_req, 0); chk("rw_outst", outstanding, 2);
    slv_rvalid = 6'b001000; slv_rdata[3] = 32'h3333_0001; #1;
    chk("rw_old1", rdata, 32'h3333_0001);
    cyc(); slv_rdata[3] = 32'h3333_0002; #1;
    chk("rw_old2", rdata, 32'h3333_0002);
    cyc(); slv_rvalid = '0; #1;
    chk("rw_new_req", slv_req, 6'b000010);
    cyc(); req = 1'b0; slv_rvalid = 6'b000010; slv_rdata[1] = 32'h1111_0004; #1;
    chk("rw_new_rd", rdata, 32'h1111_0004);
    cyc(); slv_rvalid = '0;
`endif
    // Asynchronous reset with two transactions in flight.
    req = 1'b1; addr = 32'h2000_0000;
    cyc(); addr = 32'h2000_0004;
    cyc(); slv_gnt = '0; addr = 32'h2000_0008; #1;
    chk("rr_outst2", outstanding, 2);
    rst = 1'b1; slv_gnt = '1; slv_rvalid = 6'b010000; #1;
    chk("rr_outst", outstanding, 0); chk("rr_gnt", gnt, 0); chk("rr_req", slv_req, 0);
    chk("rr_rv", rvalid, 0); chk("rr_err", err, 0); chk("rr_rd", rdata, 0);
    cyc(); cyc();
    rst = 1'b0; req = 1'b0; #1;
    chk("rr_late", rvalid, 0); chk("rr_late_outst", outstanding, 0);
    cyc(); slv_rvalid = '0; req = 1'b1; addr = 32'hF010_0004; #1;
    chk("rr_table", slv_req, 6'b001000);
    cyc(); req = 1'b0; slv_rvalid = 6'b001000; slv_rdata[3] = 32'h3333_0005; #1;
    chk("rr_rd3", rdata, 32'h3333_0005);
    cyc(); slv_rvalid = '0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
